alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Multi-cycle execute sequencer for the datapath ALU (add/sub/and/not-B unit with overflow output). It accepts one operation request, reads operands from the register file, drives the ALU operand buses and one-hot op strobes, latches the result and status flags, and optionally writes the result back. It sits between instruction decode and the register file/ALU pair, and owns the ALU's control inputs.

Parameters:
width, 16, datapath width of operands/result
regBits, 3, register-number width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  request pulse; sampled only in IDLE
opcode  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN (not B)
rn  in  regBits  operand A register number
rm  in  regBits  operand B register number
rd  in  regBits  destination register number
wb_en  in  1  1 = write result to rd; 0 = flags only (compare)
rf_rdata  in  width  register-file read data, combinational from rf_readnum
rf_readnum  out  regBits  register-file read address
rf_writenum  out  regBits  register-file write address
rf_write  out  1  register-file write strobe
rf_wdata  out  width  register-file write data
Ain  out  width  ALU operand A
Bin  out  width  ALU operand B
addSubVals  out  1  ALU add/sub select
andVals  out  1  ALU AND select
notBVal  out  1  ALU not-B select
sub  out  1  ALU subtract (valid with addSubVals)
alu_result  in  width  ALU computed value
alu_overflow  in  1  ALU overflow flag
status  out  3  {Z,N,V} registered flags
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, LOADA, LOADB, EXEC, WB, DONE.
- Reset (synchronous, wins over all): state IDLE; A, B, C, status, latched op/rn/rm/rd/wb_en = 0; all outputs 0.
- IDLE: start=1 latches opcode, rn, rm, rd, wb_en; next LOADA, or LOADB if opcode=MVN (A unused). start=0 stays IDLE. start is ignored in all other states (no queueing).
- LOADA: rf_readnum=rn; A <= rf_rdata at edge; -> LOADB.
- LOADB: rf_readnum=rm; B <= rf_rdata at edge; -> EXEC.
- rf_readnum = 0 outside LOADA/LOADB.
- EXEC: exactly one strobe high, decoded from latched opcode: ADD addSubVals=1,sub=0; SUB addSubVals=1,sub=1; AND andVals=1; MVN notBVal=1. All strobes and sub are 0 in every other state.
- EXEC edge: C <= alu_result; Z <= (alu_result==0); N <= alu_result[width-1]; V <= alu_overflow for ADD/SUB, 0 for AND/MVN. Next WB if wb_en else DONE.
- status changes only at the EXEC edge; it holds across idle periods and later operations until their EXEC.
- WB: rf_write=1, rf_writenum=rd, rf_wdata=C for exactly one cycle; -> DONE. rf_write=0 in all other states. rf_writenum/rf_wdata = 0 outside WB.
- DONE: done=1 one cycle; -> IDLE. New start accepted the cycle after DONE (in IDLE).
- Ain=A, Bin=B continuously (registered, held between operations).
- Latency (edge sampling start = cycle 0, done high in cycle N): ADD/SUB/AND with wb 5; without wb 4; MVN with wb 4; without wb 3.
- rd equal to rn or rm is legal; operands are already captured before WB.
- Arithmetic wraps mod 2^width; no saturation. Result correctness is the ALU's; this block only captures.
- Reset asserted mid-operation: abort at that edge, no WB write issued afterward, done not pulsed, status cleared to 0.

Test Plan:
- Reset then idle: all outputs 0, busy=0, status=000 for 10 cycles with start=0.
- ADD r1=0x0005 + r2=0x0003, rd=r3, wb_en=1 -> addSubVals only in cycle 3, rf_write=1 rf_writenum=3 rf_wdata=0x0008 in cycle 4, done in cycle 5, status=000.
- SUB compare r1=0x7FFF - r2=0xFFFF (wb_en=0, ALU reports overflow) -> sub=1 in EXEC, no rf_write, done in cycle 4, status Z=0,N=1,V=1.
- MVN r4=0xFFFF -> rd=r5 -> no LOADA, rf_wdata=0x0000 in cycle 3, done cycle 4, status Z=1,N=0,V=0 even if alu_overflow forced 1.
- AND 0xF0F0 & 0x0FF0 with start held high throughout -> single operation, result 0x00F0, next op begins only after DONE returns to IDLE.
- Reset pulsed in EXEC of an ADD with wb_en=1 -> next cycle IDLE, no rf_write, no done, status=000.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Bus bundle between the execute sequencer, its requester, the register
// file and the ALU. The slave modport is the sequencer's view.
interface alu_exec_ctrl_if #(
    parameter int width   = 16,
    parameter int regBits = 3
);
    // Request from decode
    logic               start;
    logic [1:0]         opcode;
    logic [regBits-1:0] rn;
    logic [regBits-1:0] rm;
    logic [regBits-1:0] rd;
    logic               wb_en;
    // Register file
    logic [width-1:0]   rf_rdata;
    logic [regBits-1:0] rf_readnum;
    logic [regBits-1:0] rf_writenum;
    logic               rf_write;
    logic [width-1:0]   rf_wdata;
    // ALU control and operands
    logic [width-1:0]   Ain;
    logic [width-1:0]   Bin;
    logic               addSubVals;
    logic               andVals;
    logic               notBVal;
    logic               sub;
    logic [width-1:0]   alu_result;
    logic               alu_overflow;
    // Status back to decode
    logic [2:0]         status;
    logic               busy;
    logic               done;

    modport slave (
        input  start, opcode, rn, rm, rd, wb_en, rf_rdata, alu_result, alu_overflow,
        output rf_readnum, rf_writenum, rf_write, rf_wdata, Ain, Bin,
               addSubVals, andVals, notBVal, sub, status, busy, done
    );

    modport master (
        output start, opcode, rn, rm, rd, wb_en, rf_rdata, alu_result, alu_overflow,
        input  rf_readnum, rf_writenum, rf_write, rf_wdata, Ain, Bin,
               addSubVals, andVals, notBVal, sub, status, busy, done
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: fetches operands from the register file,
// strobes the ALU for one cycle, captures result and {Z,N,V} flags, and
// optionally writes the result back before pulsing done.
module alu_exec_ctrl #(
    parameter int width   = 16,
    parameter int regBits = 3
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOADA, LOADB, EXEC, WB, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    state_t             state_q, state_d;
    logic [width-1:0]   a_q, a_d;
    logic [width-1:0]   b_q, b_d;
    logic [width-1:0]   c_q, c_d;
    logic [2:0]         status_q, status_d;
    logic [1:0]         op_q, op_d;
    logic [regBits-1:0] rn_q, rn_d;
    logic [regBits-1:0] rm_q, rm_d;
    logic [regBits-1:0] rd_q, rd_d;
    logic               wb_en_q, wb_en_d;

    // Operand buses and flags are straight from registers.
    assign bus.Ain    = a_q;
    assign bus.Bin    = b_q;
    assign bus.status = status_q;
    assign bus.busy   = (state_q != IDLE);

    // Next-state, datapath captures and per-state control outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        c_d             = c_q;
        status_d        = status_q;
        op_d            = op_q;
        rn_d            = rn_q;
        rm_d            = rm_q;
        rd_d            = rd_q;
        wb_en_d         = wb_en_q;
        bus.rf_readnum  = '0;
        bus.rf_writenum = '0;
        bus.rf_write    = 1'b0;
        bus.rf_wdata    = '0;
        bus.addSubVals  = 1'b0;
        bus.andVals     = 1'b0;
        bus.notBVal     = 1'b0;
        bus.sub         = 1'b0;
        bus.done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.opcode;
                    rn_d    = bus.rn;
                    rm_d    = bus.rm;
                    rd_d    = bus.rd;
                    wb_en_d = bus.wb_en;
                    // MVN only needs B, so skip the A fetch.
                    state_d = (bus.opcode == OP_MVN) ? LOADB : LOADA;
                end
            end
            LOADA: begin
                bus.rf_readnum = rn_q;
                a_d            = bus.rf_rdata;
                state_d        = LOADB;
            end
            LOADB: begin
                bus.rf_readnum = rm_q;
                b_d            = bus.rf_rdata;
                state_d        = EXEC;
            end
            EXEC: begin
                case (op_q)
                    OP_ADD:  bus.addSubVals = 1'b1;
                    OP_SUB: begin
                        bus.addSubVals = 1'b1;
                        bus.sub        = 1'b1;
                    end
                    OP_AND:  bus.andVals = 1'b1;
                    default: bus.notBVal = 1'b1;
                endcase
                c_d      = bus.alu_result;
                // Overflow is meaningful only for arithmetic ops.
                status_d = {(bus.alu_result == '0),
                            bus.alu_result[width-1],
                            bus.alu_overflow & ((op_q == OP_ADD) || (op_q == OP_SUB))};
                state_d  = wb_en_q ? WB : DONE;
            end
            WB: begin
                bus.rf_write    = 1'b1;
                bus.rf_writenum = rd_q;
                bus.rf_wdata    = c_q;
                state_d         = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update together from pre-edge values.
        if (reset) begin
            // NOTE: the latched request fields are plain flops (no RAM), so they are reset with the state.
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            op_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            wb_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
            op_q     <= op_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
            wb_en_q  <= wb_en_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural register file and
// ALU around it; expected results are queued at issue and checked at
// write-back / done.
module tb_alu_exec_ctrl;
    localparam int W = 16;
    localparam int R = 3;

    logic clk;
    logic reset;
    logic force_ovf;
    int   n_pass;
    int   n_checks;

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   st;
        logic [R-1:0] rd;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0] rf [8] = '{16'h0FF0, 16'h0005, 16'h0003, 16'h0000,
                             16'hFFFF, 16'h0000, 16'h7FFF, 16'hF0F0};

    alu_exec_ctrl_if #(.width(W), .regBits(R)) bus ();

    alu_exec_ctrl #(.width(W), .regBits(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, write on rising edge.
    assign bus.rf_rdata = rf[bus.rf_readnum];
    always @(posedge clk) if (bus.rf_write) rf[bus.rf_writenum] <= bus.rf_wdata;

    // Behavioural ALU using sign-extended arithmetic for overflow.
    logic signed [W:0] ext;
    always_comb begin
        ext = '0;
        bus.alu_result = '0;
        if (bus.addSubVals && !bus.sub) begin
            ext = {bus.Ain[W-1], bus.Ain} + {bus.Bin[W-1], bus.Bin};
            bus.alu_result = ext[W-1:0];
        end else if (bus.addSubVals) begin
            ext = {bus.Ain[W-1], bus.Ain} - {bus.Bin[W-1], bus.Bin};
            bus.alu_result = ext[W-1:0];
        end else if (bus.andVals) begin
            bus.alu_result = bus.Ain & bus.Bin;
        end else if (bus.notBVal) begin
            bus.alu_result = ~bus.Bin;
        end
        bus.alu_overflow = (ext[W] != ext[W-1]) | force_ovf;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [R-1:0] d);
        exp_t e;
        logic v;
        v = 1'b0;
        case (op)
            2'b00: begin e.res = a + b; v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]); end
            2'b01: begin e.res = a - b; v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]); end
            2'b10: e.res = a & b;
            default: e.res = ~b;
        endcase
        e.st = {(e.res == '0), e.res[W-1], v};
        e.rd = d;
        return e;
    endfunction

    // Issue one operation and check every cycle until it returns to IDLE.
    // abort_at > 0 asserts reset after sampling that cycle.
    task automatic run_op(input logic [1:0] op, input logic [R-1:0] n, input logic [R-1:0] m,
                          input logic [R-1:0] d, input logic wb, input logic hold,
                          input int abort_at);
        int lat, exec_c, wb_c;
        logic [3:0]   strb;
        logic [R-1:0] rnum;
        logic [W-1:0] a, b;
        exp_t e;
        a = rf[n];
        b = rf[m];
        lat    = ((op == 2'b11) ? 3 : 4) + int'(wb);
        exec_c = wb ? lat - 2 : lat - 1;
        wb_c   = wb ? lat - 1 : -1;
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.rn = n; bus.rm = m; bus.rd = d; bus.wb_en = wb;
        sb.push_back(model(op, a, b, d));
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (!hold || k == lat) bus.start = 1'b0;
            strb = 4'b0000;
            if (k == exec_c)
                case (op)
                    2'b00: strb = 4'b1000;
                    2'b01: strb = 4'b1001;
                    2'b10: strb = 4'b0100;
                    default: strb = 4'b0010;
                endcase
            rnum = '0;
            if (k == exec_c - 1) rnum = m;
            else if (k == exec_c - 2) rnum = n;
            check($sformatf("strobes c%0d", k),
                  64'({bus.addSubVals, bus.andVals, bus.notBVal, bus.sub}), 64'(strb));
            check($sformatf("readnum c%0d", k), 64'(bus.rf_readnum), 64'(rnum));
            check($sformatf("rf_write c%0d", k), 64'(bus.rf_write), 64'(k == wb_c));
            check($sformatf("done c%0d", k), 64'(bus.done), 64'(k == lat));
            check($sformatf("busy c%0d", k), 64'(bus.busy), 64'd1);
            if (k == exec_c) begin
                check("Bin", 64'(bus.Bin), 64'(b));
                if (op != 2'b11) check("Ain", 64'(bus.Ain), 64'(a));
            end
            if (k == wb_c) begin
                check("wdata", 64'(bus.rf_wdata), 64'(sb[0].res));
                check("writenum", 64'(bus.rf_writenum), 64'(sb[0].rd));
            end
            if (k == lat) begin
                e = sb.pop_front();
                check("status", 64'(bus.status), 64'(e.st));
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                void'(sb.pop_front());
                check("abort busy", 64'(bus.busy), 64'd0);
                check("abort status", 64'(bus.status), 64'd0);
                for (int j = 0; j < 6; j++) begin
                    check("abort no wb/done", 64'({bus.rf_write, bus.done}), 64'd0);
                    @(negedge clk);
                end
                return;
            end
        end
        @(negedge clk);
        check("back to idle", 64'({bus.busy, bus.done, bus.rf_write}), 64'd0);
    endtask

    initial begin
        n_pass = 0; n_checks = 0; force_ovf = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.opcode = '0; bus.rn = '0; bus.rm = '0; bus.rd = '0; bus.wb_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        // Idle after reset: every output low.
        for (int i = 0; i < 10; i++) begin
            check("idle outputs",
                  {bus.rf_readnum, bus.rf_writenum, bus.rf_write, bus.rf_wdata, bus.Ain, bus.Bin,
                   bus.addSubVals, bus.andVals, bus.notBVal, bus.sub, bus.status, bus.busy, bus.done},
                  64'd0);
            @(negedge clk);
        end
        // ADD r1+r2 -> r3 with write-back.
        run_op(2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 0);
        // SUB compare 0x7FFF - 0xFFFF: overflow, no write-back.
        run_op(2'b01, 3'd6, 3'd4, 3'd0, 1'b0, 1'b0, 0);
        // ADD aborted by reset during EXEC.
        run_op(2'b00, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, 3);
        // MVN of 0xFFFF with the ALU claiming overflow.
        force_ovf = 1'b1;
        run_op(2'b11, 3'd0, 3'd4, 3'd5, 1'b1, 1'b0, 0);
        force_ovf = 1'b0;
        // AND with start held high, destination equal to rn.
        run_op(2'b10, 3'd7, 3'd0, 3'd7, 1'b1, 1'b1, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
